fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
// - Instruction-fetch sequencer for the IF stage: drives load/pc_sel of the PC register and issues imem requests (valid/ready).
// - Buffers fetched {pc, instr} pairs for decode.
// - Applies EX-stage redirects (JAL/JALR/BRANCH) and squashes wrong-path fetches.
// - Sits between the PC register, instruction memory and the IF/ID boundary.
// PARAMETERS
// - DEPTH  2   fetch-buffer entries; power of 2, >= 2
// PORTS
// - clock            in   1   single clock, all state on posedge
// - reset            in   1   synchronous, active-high
// - pc               in   32  current PC register value
// - pc_load          out  1   PC register load enable
// - pc_sel           out  2   next-PC select, `PC_PLUS_4/`PC_JAL/`PC_JALR/`PC_BRANCH
// - redirect_valid   in   1   EX resolved a taken control transfer this cycle
// - redirect_sel     in   2   `PC_JAL/`PC_JALR/`PC_BRANCH, never `PC_PLUS_4
// - imem_req_valid   out  1   fetch request valid
// - imem_req_ready   in   1   imem accepts request
// - imem_addr        out  32  fetch address (= pc while in REQ)
// - imem_resp_valid  in   1   response present, exactly one per accepted request, >= 1 cycle later
// - imem_resp_data   in   32  fetched instruction
// - if_valid         out  1   fetch-buffer head valid
// - if_pc            out  32  head PC
// - if_instr         out  32  head instruction
// - id_ready         in   1   decode pops head when if_valid & id_ready
// BEHAVIOUR
// - FSM states: REQ, WAIT, STALL, DRAIN.
//   - Reset -> REQ; buffer emptied.
//   - Reset values: pc_load=0, pc_sel=`PC_PLUS_4, imem_req_valid=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0.
// - REQ:
//   - imem_req_valid=1, imem_addr=pc.
//   - On imem_req_ready: capture req_pc<=pc, go to WAIT.
//   - Never requests while the buffer is full; go to STALL instead.
// - WAIT:
//   - On imem_resp_valid: push {req_pc, imem_resp_data}, pulse pc_load=1 with pc_sel=`PC_PLUS_4.
//   - Next state is REQ if the buffer is not full after push/pop, else STALL.
//   - Fetch latency: one response cycle to push; if_valid rises the cycle after the push.
// - STALL: leave to REQ in the cycle after a pop frees an entry.
// - DRAIN:
//   - Wrong-path response outstanding.
//   - Next imem_resp_valid is discarded (no push, no pc_load); then REQ.
// - Redirect (any state), priority over sequential increment:
//   - pc_load=1, pc_sel=redirect_sel, buffer flushed the same cycle.
//   - A pop in the same cycle is ignored.
//   - REQ, handshake completes same cycle: old-pc request in flight -> DRAIN.
//   - REQ, no handshake: -> REQ; next cycle requests the new pc.
//   - WAIT, no response this cycle: -> DRAIN.
//   - WAIT, response this cycle: response dropped, no push -> REQ.
//   - STALL: -> REQ.
//   - DRAIN: stay DRAIN (response still pending); a response in the same cycle is dropped -> REQ.
// - pc_load is 1 at most once per cycle and only in the cases above; otherwise 0 with pc_sel=`PC_PLUS_4.
// - Buffer: circular; push and pop in the same cycle are legal when full (pop frees the slot first).
//   - Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
// - Reset mid-operation discards any outstanding response: imem must also be reset.
//   - FSM restarts in REQ with an empty buffer.
// - Assertions: redirect_sel != `PC_PLUS_4 when redirect_valid; no imem_resp_valid in REQ or STALL.
// STRUCTURE
// - Shared codes.v: PC_* select codes (existing); add FETCH_REQ/WAIT/STALL/DRAIN state encodings (2 bits).
// - Sub-module fetch_buf: DEPTH x 64-bit FIFO with push, pop, flush, full, empty, head outputs.
// - fetch_ctrl holds the FSM, req_pc register and pc_load/pc_sel decode.
// TESTING
// - Sequential fetch, zero-wait imem, id_ready=1: pc 0,4,8,C fetched in order; if_pc matches; one pc_load/`PC_PLUS_4 per response.
// - Backpressure, id_ready=0, DEPTH=2: exactly 2 pushes, then STALL with imem_req_valid=0; one pop -> REQ next cycle, fetch resumes at pc=8.
// - Redirect in WAIT: request at pc=0x10, redirect_valid `PC_JAL (jal=0x100) before response -> buffer flushed, response discarded, next request addr=0x100.
// - Redirect same cycle as response: response at 0x20 dropped, pc_sel=`PC_BRANCH, no push, next request at branch target.
// - imem_req_ready held low 5 cycles: imem_req_valid stays 1, imem_addr stable, pc_load stays 0.
// - Reset asserted in WAIT with 1 buffered entry: next cycle if_valid=0, pc_load=0, state REQ.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage codes: next-PC select values, fetch FSM states and the buffered {pc, instr} entry.
package fetch_ctrl_pkg;

  localparam logic [1:0] PC_PLUS_4 = 2'd0;
  localparam logic [1:0] PC_JAL    = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_STALL = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_redirect_sel(input logic [1:0] sel);
    return (sel == PC_JAL) || (sel == PC_JALR) || (sel == PC_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Circular DEPTH-entry buffer of fetched {pc, instr} pairs; head is combinational, zero when empty.
// A pop frees its slot first, so push and pop together are accepted even when full.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_dat_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic                   full_o,
  output logic                   empty_o,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: issues one imem request at a time, buffers responses for decode and applies EX redirects.
// Responses push the same cycle they arrive; decode sees them the cycle after.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   req_pc_q;
  logic          redir, req_fire, resp_push, buf_pop;
  logic          buf_full, buf_empty, full_after;
  logic [CW-1:0] buf_count;
  fetch_entry_t  buf_head, push_dat;

  assign redir          = redirect_valid && !reset;
  assign imem_req_valid = !reset && (state_q == FETCH_REQ) && !buf_full;
  assign imem_addr      = (!reset && (state_q == FETCH_REQ)) ? pc : '0;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_push      = !reset && (state_q == FETCH_WAIT) && imem_resp_valid && !redir;
  assign buf_pop        = if_valid && id_ready && !redir;
  assign pc_load        = redir || resp_push;
  assign pc_sel         = redir ? redirect_sel : PC_PLUS_4;
  assign push_dat       = '{pc: req_pc_q, instr: imem_resp_data};

  // Occupancy after this cycle's push/pop decides between REQ and STALL.
  always_comb begin
    full_after = 1'b0;
    if (resp_push && !buf_pop) begin
      full_after = (buf_count == CW'(DEPTH - 1));
    end else if (resp_push == buf_pop) begin
      full_after = buf_full;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_REQ: begin
        if (redir)          state_d = req_fire ? FETCH_DRAIN : FETCH_REQ;
        else if (buf_full)  state_d = FETCH_STALL;
        else if (req_fire)  state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) state_d = (redir || !full_after) ? FETCH_REQ : FETCH_STALL;
        else if (redir)      state_d = FETCH_DRAIN;
      end
      FETCH_STALL: if (redir || buf_pop) state_d = FETCH_REQ;
      FETCH_DRAIN: if (imem_resp_valid)  state_d = FETCH_REQ;
      default:     state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FETCH_REQ;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) req_pc_q <= pc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (redirect_valid) assert (is_redirect_sel(redirect_sel));
      if ((state_q == FETCH_REQ) || (state_q == FETCH_STALL)) assert (!imem_resp_valid);
    end
  end

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (resp_push),
    .push_dat_i (push_dat),
    .pop_i      (buf_pop),
    .flush_i    (redir),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .head_o     (buf_head),
    .count_o    (buf_count)
  );

  assign if_valid = !buf_empty;
  assign if_pc    = buf_head.pc;
  assign if_instr = buf_head.instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: models the PC register and a single-outstanding imem around the DUT.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  always #5 clock = ~clock;

  fetch_ctrl #(.DEPTH(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .pc_load         (pc_load),
    .pc_sel          (pc_sel),
    .redirect_valid  (redirect_valid),
    .redirect_sel    (redirect_sel),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .id_ready        (id_ready)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          load_cnt = 0;
  int          base;
  logic [63:0] exp_fetch[$];
  logic [1:0]  exp_sel[$];
  int          budget = 0;
  int          lat = 1;
  int          pend = 0;
  logic [31:0] pend_addr = '0;
  logic        last_fire_vld = 1'b0;
  logic [31:0] last_fire_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [1:0] sel, input logic [31:0] cur);
    case (sel)
      PC_JAL:    return 32'h0000_0100;
      PC_JALR:   return 32'h0000_0300;
      PC_BRANCH: return 32'h0000_0200;
      default:   return cur + 32'd4;
    endcase
  endfunction

  task automatic set_budget(input int n);
    budget = n;
    imem_req_ready = (n != 0);
  endtask

  // One clock: sample at negedge, then update PC register and imem model just after posedge.
  task automatic tick();
    logic        s_ld, s_fire, s_rv, s_rst;
    logic [1:0]  s_sel;
    logic [31:0] s_addr;
    @(negedge clock);
    s_ld = pc_load; s_sel = pc_sel; s_rv = imem_resp_valid; s_rst = reset;
    s_fire = imem_req_valid && imem_req_ready; s_addr = imem_addr;
    @(posedge clock);
    #1;
    if (s_ld) pc = next_pc(s_sel, pc);
    last_fire_vld = s_fire;
    last_fire_addr = s_addr;
    if (s_rst) begin
      pend = 0;
      imem_resp_valid = 1'b0;
    end else begin
      if (s_rv) imem_resp_valid = 1'b0;
      if (s_fire) begin
        pend = lat;
        pend_addr = s_addr;
        if (budget > 0) budget--;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data = {16'hC0DE, pend_addr[15:0]};
        end
      end
    end
    imem_req_ready = (budget != 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_sel = PC_JAL;
    id_ready = 1'b0; pc = 32'h0; set_budget(0);
    tick();
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_pc_sel", 32'(pc_sel), 32'(PC_PLUS_4));
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    tick();
    reset = 1'b0; pc = 32'h0;
    #1;
    chk("rst_release_req", 32'(imem_req_valid), 32'd1);
  endtask

  task automatic wait_fire(input logic [31:0] addr, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (last_fire_vld && last_fire_addr == addr) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_loads(input int n, input string nm);
    for (int i = 0; i < 40 && load_cnt < n; i++) tick();
    chk(nm, 32'(load_cnt), 32'(n));
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 60 && (exp_fetch.size() + exp_sel.size()) != 0; i++) tick();
    chk(nm, 32'(exp_fetch.size() + exp_sel.size()), 32'd0);
  endtask

  // Monitor: every pc_load and every decode pop is matched against the scoreboard queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (pc_load) begin
        load_cnt++;
        if (exp_sel.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL pc_load_unexpected: got sel %0d, expected no load", pc_sel);
        end else begin
          chk("pc_sel", 32'(pc_sel), 32'(exp_sel.pop_front()));
        end
      end
      if (if_valid && id_ready && !redirect_valid) begin
        if (exp_fetch.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL pop_unexpected: got pc 0x%08h, expected no entry", if_pc);
        end else begin
          logic [63:0] e;
          e = exp_fetch.pop_front();
          chk("if_pc", if_pc, e[63:32]);
          chk("if_instr", if_instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    imem_resp_valid = 1'b0; imem_resp_data = '0; imem_req_ready = 1'b0;

    // Sequential fetch, zero-wait imem, decode always ready.
    do_reset();
    lat = 1; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_sel.push_back(PC_PLUS_4);
      exp_fetch.push_back({32'(4 * i), 16'hC0DE, 16'(4 * i)});
    end
    set_budget(4);
    wait_empty("seq_drain");
    tick(); #1;
    chk("seq_next_addr", imem_addr, 32'h10);

    // imem not ready: request held stable, no PC loads.
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
      chk("hold_addr", imem_addr, 32'h10);
      chk("hold_pc_load", 32'(pc_load), 32'd0);
    end

    // Backpressure with DEPTH=2.
    do_reset();
    base = load_cnt; lat = 1; id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_sel.push_back(PC_PLUS_4);
      exp_fetch.push_back({32'(4 * i), 16'hC0DE, 16'(4 * i)});
    end
    set_budget(3);
    wait_loads(base + 2, "bp_two_loads");
    #1;
    chk("bp_stall_req", 32'(imem_req_valid), 32'd0);
    chk("bp_head_pc", if_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("bp_stall_hold", 32'(imem_req_valid), 32'd0);
      chk("bp_load_cnt", 32'(load_cnt), 32'(base + 2));
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #1;
    chk("bp_resume_req", 32'(imem_req_valid), 32'd1);
    chk("bp_resume_addr", imem_addr, 32'h8);
    wait_loads(base + 3, "bp_third_load");
    id_ready = 1'b1;
    wait_empty("bp_drain");

    // Redirect in WAIT before the response arrives.
    do_reset();
    pc = 32'hC; lat = 3; id_ready = 1'b0;
    exp_sel.push_back(PC_PLUS_4);
    exp_sel.push_back(PC_JAL);
    exp_sel.push_back(PC_PLUS_4);
    exp_fetch.push_back({32'h100, 32'hC0DE_0100});
    set_budget(3);
    wait_fire(32'h10, "r3_fire_10");
    redirect_valid = 1'b1; redirect_sel = PC_JAL;
    #1;
    chk("r3_pc_load", 32'(pc_load), 32'd1);
    chk("r3_buffered", 32'(if_valid), 32'd1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("r3_flushed", 32'(if_valid), 32'd0);
    chk("r3_drain_noreq", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 10 && !imem_req_valid; i++) begin
      tick(); #1;
    end
    chk("r3_new_req", 32'(imem_req_valid), 32'd1);
    chk("r3_new_addr", imem_addr, 32'h100);
    chk("r3_discarded", 32'(if_valid), 32'd0);
    id_ready = 1'b1;
    wait_empty("r3_drain");

    // Redirect in the same cycle as the response.
    do_reset();
    pc = 32'h20; lat = 2; id_ready = 1'b1;
    exp_sel.push_back(PC_BRANCH);
    exp_sel.push_back(PC_PLUS_4);
    exp_fetch.push_back({32'h200, 32'hC0DE_0200});
    set_budget(2);
    wait_fire(32'h20, "r4_fire_20");
    tick();
    redirect_valid = 1'b1; redirect_sel = PC_BRANCH;
    #1;
    chk("r4_pc_load", 32'(pc_load), 32'd1);
    chk("r4_pc_sel", 32'(pc_sel), 32'(PC_BRANCH));
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("r4_no_push", 32'(if_valid), 32'd0);
    chk("r4_req", 32'(imem_req_valid), 32'd1);
    chk("r4_addr", imem_addr, 32'h200);
    wait_empty("r4_drain");

    // Reset in WAIT with one buffered entry.
    do_reset();
    base = load_cnt; lat = 4; id_ready = 1'b0;
    exp_sel.push_back(PC_PLUS_4);
    set_budget(2);
    wait_fire(32'h4, "r6_fire_4");
    #1;
    chk("r6_one_entry", 32'(if_valid), 32'd1);
    chk("r6_head_pc", if_pc, 32'h0);
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    #1;
    chk("r6_no_stale_push", 32'(if_valid), 32'd0);
    chk("r6_loads", 32'(load_cnt), 32'(base + 1));
    wait_empty("r6_queues");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
